// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Sits between a byte-wide serial link and an ALU. Receive bytes are
//   assembled into a command frame (header, operand A, operand B), the ALU
//   is started with a one-cycle Enable, the 2*WIDTH-bit result is captured on
//   OUT_VALID and streamed back out LSB first. If the ALU never answers, a
//   watchdog substitutes a single ERR_BYTE so the link always gets a reply.
//
//   Frame: header {4'hA, fun}, then NB_OP bytes of A (LSB first), then NB_OP
//   bytes of B (LSB first).
//
// Parameters:
//   WIDTH    ALU operand width, multiple of 8
//   TIMEOUT  cycles after Enable during which OUT_VALID is honoured (>= 2)
//   ERR_BYTE byte sent when the watchdog expires
//
// Ports:
//   clk        in   rising-edge clock
//   RST        in   synchronous active-high reset
//   RX_P_DATA  in   received byte
//   RX_D_VLD   in   one-cycle strobe, RX_P_DATA valid
//   A, B       out  operands to the ALU (held until the next frame)
//   ALU_FUN    out  ALU function code (header low nibble)
//   Enable     out  one-cycle ALU start pulse
//   ALU_OUT    in   ALU result
//   OUT_VALID  in   ALU result valid (only looked at while waiting)
//   TX_P_DATA  out  byte to the transmitter
//   TX_D_VLD   out  TX_P_DATA valid; transfer when TX_BUSY is low
//   TX_BUSY    in   transmitter back-pressure
//   RX_DROP    out  one-cycle pulse when a received byte is discarded
//   BUSY       out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int         WIDTH    = 16,
  parameter int         TIMEOUT  = 15,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [7:0]           RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [3:0]           ALU_FUN,
  output logic                 Enable,
  input  logic [2*WIDTH-1:0]   ALU_OUT,
  input  logic                 OUT_VALID,
  output logic [7:0]           TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 TX_BUSY,
  output logic                 RX_DROP,
  output logic                 BUSY
);

  localparam int NB_OP  = WIDTH / 8;
  localparam int NB_RES = (2 * WIDTH) / 8;
  localparam int CNT_W  = (NB_RES > 1) ? $clog2(NB_RES) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_OP  = CNT_W'(NB_OP - 1);
  localparam logic [CNT_W-1:0] LAST_RES = CNT_W'(NB_RES - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WAIT,
    S_SEND,
    S_ERR
  } state_t;

  // Registered state and outputs
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WD_W-1:0]      r_wdog;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [3:0]           r_fun;
  logic [2*WIDTH-1:0]   r_res;
  logic                 r_enable;
  logic [7:0]           r_tx_data;
  logic                 r_tx_vld;
  logic                 r_rx_drop;
  logic                 r_busy;

  // Next-state / control wires
  state_t               w_state_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [WD_W-1:0]      w_wdog_next;
  logic [WD_W-1:0]      w_wdog_inc;
  logic [3:0]           w_fun_next;
  logic                 w_a_we;
  logic                 w_b_we;
  logic                 w_res_we;
  logic [7:0]           w_tx_data_next;
  logic                 w_tx_vld_next;
  logic                 w_rx_drop_next;
  logic                 w_enable_next;
  logic                 w_busy_next;

  // Result register viewed as bytes so SEND can pick byte[cnt] directly.
  logic [7:0]           w_res_byte [NB_RES];

  genvar gi;
  generate
    for (gi = 0; gi < NB_RES; gi++) begin : g_res_bytes
      assign w_res_byte[gi] = r_res[gi*8 +: 8];
    end
  endgenerate

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_wdog_inc = r_wdog + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_wdog_next    = r_wdog;
    w_fun_next     = r_fun;
    w_a_we         = 1'b0;
    w_b_we         = 1'b0;
    w_res_we       = 1'b0;
    w_tx_data_next = r_tx_data;
    w_tx_vld_next  = r_tx_vld;
    w_rx_drop_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA[7:4] == 4'hA) begin
            w_fun_next   = RX_P_DATA[3:0];
            w_cnt_next   = '0;
            w_state_next = S_GET_A;
          end else begin
            w_rx_drop_next = 1'b1;
          end
        end
      end

      // Inside a frame every byte is payload, even one that looks like a header.
      S_GET_A: begin
        if (RX_D_VLD) begin
          w_a_we = 1'b1;
          if (r_cnt == LAST_OP) begin
            w_cnt_next   = '0;
            w_state_next = S_GET_B;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end

      S_GET_B: begin
        if (RX_D_VLD) begin
          w_b_we = 1'b1;
          if (r_cnt == LAST_OP) begin
            w_cnt_next   = '0;
            w_state_next = S_EXEC;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end

      S_EXEC: begin
        w_rx_drop_next = RX_D_VLD;
        w_wdog_next    = '0;
        w_state_next   = S_WAIT;
      end

      // r_wdog holds (cycles since Enable - 1), so the TIMEOUT-th WAIT cycle is
      // the one where the incremented value hits the limit. OUT_VALID is tested
      // first so it wins a tie with the watchdog.
      S_WAIT: begin
        w_rx_drop_next = RX_D_VLD;
        w_wdog_next    = w_wdog_inc;
        if (OUT_VALID) begin
          w_res_we       = 1'b1;
          w_cnt_next     = '0;
          w_tx_data_next = ALU_OUT[7:0];
          w_tx_vld_next  = 1'b1;
          w_state_next   = S_SEND;
        end else if (w_wdog_inc == WD_LIMIT) begin
          w_tx_data_next = ERR_BYTE;
          w_tx_vld_next  = 1'b1;
          w_state_next   = S_ERR;
        end
      end

      // The byte on TX_P_DATA is always result byte[cnt]; the next byte is
      // preloaded on the transfer edge so consecutive bytes need no gap.
      S_SEND: begin
        w_rx_drop_next = RX_D_VLD;
        if (!TX_BUSY) begin
          if (r_cnt == LAST_RES) begin
            w_cnt_next    = '0;
            w_tx_vld_next = 1'b0;
            w_state_next  = S_IDLE;
          end else begin
            w_cnt_next     = w_cnt_inc;
            w_tx_data_next = w_res_byte[w_cnt_inc];
          end
        end
      end

      S_ERR: begin
        w_rx_drop_next = RX_D_VLD;
        if (!TX_BUSY) begin
          w_tx_vld_next = 1'b0;
          w_state_next  = S_IDLE;
        end
      end

      default: begin
        w_state_next  = S_IDLE;
        w_tx_vld_next = 1'b0;
      end
    endcase

    w_enable_next = (w_state_next == S_EXEC);
    w_busy_next   = (w_state_next != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_fun     <= '0;
      r_enable  <= 1'b0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_rx_drop <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_wdog    <= w_wdog_next;
      r_fun     <= w_fun_next;
      r_enable  <= w_enable_next;
      r_tx_data <= w_tx_data_next;
      r_tx_vld  <= w_tx_vld_next;
      r_rx_drop <= w_rx_drop_next;
      r_busy    <= w_busy_next;
    end
  end

  // Operand and result capture. Operands are written byte by byte in place,
  // so they only change while a new frame is being received.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      for (int i = 0; i < NB_OP; i++) begin
        if (w_a_we && (r_cnt == CNT_W'(i))) begin
          r_a[i*8 +: 8] <= RX_P_DATA;
        end
        if (w_b_we && (r_cnt == CNT_W'(i))) begin
          r_b[i*8 +: 8] <= RX_P_DATA;
        end
      end
      if (w_res_we) begin
        r_res <= ALU_OUT;
      end
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign ALU_FUN   = r_fun;
  assign Enable    = r_enable;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign RX_DROP   = r_rx_drop;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_cmd_sequencer.
// The bench keeps a transaction-level model: queues of expected frames and
// expected TX bytes, the expected Enable / RX_DROP cycles and the expected
// first-byte latency. One monitor compares the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int W = 16;
  localparam int T = 15;

  logic            clk = 1'b0;
  logic            RST;
  logic [7:0]      RX_P_DATA;
  logic            RX_D_VLD;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic [3:0]      ALU_FUN;
  logic            Enable;
  logic [2*W-1:0]  ALU_OUT;
  logic            OUT_VALID;
  logic [7:0]      TX_P_DATA;
  logic            TX_D_VLD;
  logic            TX_BUSY;
  logic            RX_DROP;
  logic            BUSY;

  alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT(T), .ERR_BYTE(8'hEE)) dut (
    .clk       (clk),
    .RST       (RST),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .Enable    (Enable),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_BUSY   (TX_BUSY),
    .RX_DROP   (RX_DROP),
    .BUSY      (BUSY)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model state
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
  } frame_t;

  frame_t      exp_frames[$];
  logic [7:0]  exp_tx[$];
  int          cyc = 0;
  int          exp_en_cyc = -1;
  int          exp_drop_cyc = -1;
  int          exp_lat = 0;
  int          en_seen_cyc = 0;
  int          idle_chk_cyc = -1;
  bit          mon_en = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  int          alu_delay = 0;      // 0 = ALU never answers
  bit          alu_force = 0;
  logic [31:0] alu_force_val = '0;
  bit          alu_busy = 0;
  int          busy_mode = 0;      // 0 low, 1 random, 2 three busy cycles per byte

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference ALU behaviour (the thing the sequencer is talking to).
  function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [15:0] a,
                                        input logic [15:0] b);
    case (f)
      4'd0:    return {16'h0, a} + {16'h0, b};
      4'd1:    return {16'h0, a} - {16'h0, b};
      4'd2:    return 32'(a) * 32'(b);
      4'd3:    return {a, b};
      default: return {~a, b ^ {12'h0, f}};
    endcase
  endfunction

  // ---------------------------------------------------------------- ALU model
  initial begin
    logic [31:0] resp;
    OUT_VALID = 1'b0;
    ALU_OUT   = '0;
    forever begin
      @(negedge clk);
      if (Enable === 1'b1 && RST === 1'b0 && alu_delay > 0) begin
        resp = alu_force ? alu_force_val : alu_f(ALU_FUN, A, B);
        repeat (alu_delay) @(posedge clk);
        #1;
        OUT_VALID = 1'b1;
        ALU_OUT   = resp;
        @(posedge clk);
        #1;
        OUT_VALID = 1'b0;
        ALU_OUT   = $urandom;
        alu_busy  = 0;
      end
    end
  end

  // ---------------------------------------------------------------- TX sink
  int busy_run = 0;
  always @(posedge clk) begin
    #1;
    case (busy_mode)
      1: TX_BUSY = ($urandom_range(0, 2) == 0);
      2: begin
        if (TX_D_VLD && busy_run < 3) begin
          TX_BUSY  = 1'b1;
          busy_run = busy_run + 1;
        end else begin
          TX_BUSY  = 1'b0;
          busy_run = 0;
        end
      end
      default: TX_BUSY = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- monitor
  logic   prev_vld;
  logic   prev_busy;
  logic [7:0] prev_data;
  frame_t mon_fr;

  always @(negedge clk) begin
    if (RST !== 1'b0 || !mon_en) begin
      prev_vld  = 1'b0;
      prev_busy = 1'b0;
      prev_data = '0;
    end else begin
      chk("enable", Enable, (cyc == exp_en_cyc));
      chk("rx_drop", RX_DROP, (cyc == exp_drop_cyc));
      if (Enable) begin
        en_seen_cyc = cyc;
        if (exp_frames.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL enable_unexpected @cyc %0d: got Enable=1 expected no frame", cyc);
        end else begin
          mon_fr = exp_frames.pop_front();
          chk("A", A, mon_fr.a);
          chk("B", B, mon_fr.b);
          chk("ALU_FUN", ALU_FUN, mon_fr.fun);
        end
      end
      if (prev_vld && prev_busy) begin
        chk("tx_hold_vld", TX_D_VLD, 1);
        chk("tx_hold_data", TX_P_DATA, prev_data);
      end
      if (TX_D_VLD && !prev_vld) chk("tx_latency", cyc - en_seen_cyc, exp_lat);
      if (TX_D_VLD && !TX_BUSY) begin
        if (exp_tx.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected @cyc %0d: got byte %0h expected none", cyc, TX_P_DATA);
        end else begin
          chk("tx_byte", TX_P_DATA, exp_tx.pop_front());
          if (exp_tx.size() == 0) idle_chk_cyc = cyc + 1;
        end
      end
      if (cyc == idle_chk_cyc) chk("busy_after_tx", BUSY, 0);
      prev_vld  = TX_D_VLD;
      prev_busy = TX_BUSY;
      prev_data = TX_P_DATA;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic send_byte(input logic [7:0] v, input bit drop, input bit last);
    int k;
    k = cyc;
    RX_P_DATA = v;
    RX_D_VLD  = 1'b1;
    if (drop) exp_drop_cyc = k + 1;
    if (last) exp_en_cyc = k + 1;
    @(posedge clk); #1;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    frame_t fr;
    fr.a = a; fr.b = b; fr.fun = f;
    exp_frames.push_back(fr);
    send_byte({4'hA, f}, 0, 0);
    send_byte(a[7:0], 0, 0);
    send_byte(a[15:8], 0, 0);
    send_byte(b[7:0], 0, 0);
    send_byte(b[15:8], 0, 1);
  endtask

  // Configure the ALU for the next frame; optionally derive the expected reply.
  task automatic plan_frame(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                            input int d, input bit frc, input logic [31:0] fv, input bit push);
    logic [31:0] r;
    alu_delay     = d;
    alu_force     = frc;
    alu_force_val = fv;
    alu_busy      = (d > 0);
    if (d >= 1 && d <= T) begin
      exp_lat = d + 1;
      r = frc ? fv : alu_f(f, a, b);
      if (push) for (int i = 0; i < 4; i++) exp_tx.push_back(r[i*8 +: 8]);
    end else begin
      exp_lat = T + 1;
      if (push) exp_tx.push_back(8'hEE);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (exp_tx.size() == 0 && BUSY === 1'b0 && !alu_busy) ok = 1;
      else begin @(posedge clk); #1; end
    end
    chk({nm, "_done"}, ok, 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_A"}, A, 0);
    chk({nm, "_B"}, B, 0);
    chk({nm, "_ALU_FUN"}, ALU_FUN, 0);
    chk({nm, "_Enable"}, Enable, 0);
    chk({nm, "_TX_P_DATA"}, TX_P_DATA, 0);
    chk({nm, "_TX_D_VLD"}, TX_D_VLD, 0);
    chk({nm, "_RX_DROP"}, RX_DROP, 0);
    chk({nm, "_BUSY"}, BUSY, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  f;
    logic [15:0] ra, rb;
    logic [7:0]  g;
    int          d;

    RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = '0; TX_BUSY = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("rst0");
    repeat (2) @(posedge clk); #1;
    RST = 1'b0;
    mon_en = 1;

    // Basic add: 3 + 4 = 7, ALU answers two cycles after Enable.
    plan_frame(4'h0, 16'h0003, 16'h0004, 2, 0, 0, 0);
    exp_tx.push_back(8'h07); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    send_frame(4'h0, 16'h0003, 16'h0004);
    wait_idle("t1");

    // Garbage byte in IDLE, then a frame with fun=3.
    send_byte(8'h55, 1, 0);
    plan_frame(4'h3, 16'h3412, 16'h7856, 1, 0, 0, 1);
    send_frame(4'h3, 16'h3412, 16'h7856);
    wait_idle("t2");

    // ALU never answers: single error byte.
    plan_frame(4'h5, 16'h1111, 16'h2222, 0, 0, 0, 0);
    exp_tx.push_back(8'hEE);
    send_frame(4'h5, 16'h1111, 16'h2222);
    wait_idle("t3");

    // Late OUT_VALID after the error byte has gone must be ignored.
    plan_frame(4'h2, 16'h0102, 16'h0304, T + 3, 0, 0, 1);
    send_frame(4'h2, 16'h0102, 16'h0304);
    wait_idle("t3b");
    repeat (3) @(posedge clk); #1;
    chk("late_tx_vld", TX_D_VLD, 0);
    chk("late_busy", BUSY, 0);

    // Watchdog boundaries: answer on the last allowed cycle, and one too late.
    plan_frame(4'h1, 16'h00AA, 16'h0011, T, 0, 0, 1);
    send_frame(4'h1, 16'h00AA, 16'h0011);
    wait_idle("t_edge_in");
    plan_frame(4'h1, 16'h00AA, 16'h0011, T + 1, 0, 0, 1);
    send_frame(4'h1, 16'h00AA, 16'h0011);
    wait_idle("t_edge_out");

    // 0xDEADBEEF with three busy cycles per byte.
    busy_mode = 2;
    plan_frame(4'h7, 16'h4242, 16'h2424, 3, 1, 32'hDEADBEEF, 0);
    exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hAD); exp_tx.push_back(8'hDE);
    send_frame(4'h7, 16'h4242, 16'h2424);
    wait_idle("t4");
    busy_mode = 0;

    // RX byte while waiting for the ALU is dropped; operands unchanged.
    plan_frame(4'h0, 16'h1234, 16'h0F0F, 5, 0, 0, 1);
    send_frame(4'h0, 16'h1234, 16'h0F0F);
    send_byte(8'hA9, 1, 0);
    wait_idle("t5");
    chk("t5_A", A, 16'h1234);
    chk("t5_B", B, 16'h0F0F);
    chk("t5_FUN", ALU_FUN, 4'h0);

    // Reset in the middle of operand B, then a fresh frame.
    send_byte(8'hA6, 0, 0);
    send_byte(8'h77, 0, 0);
    send_byte(8'h66, 0, 0);
    send_byte(8'h55, 0, 0);
    mon_en = 0;
    RST = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rst_mid");
    RST = 1'b0;
    exp_en_cyc = -1; exp_drop_cyc = -1;
    mon_en = 1;
    plan_frame(4'h0, 16'h0100, 16'h0023, 2, 0, 0, 1);
    send_frame(4'h0, 16'h0100, 16'h0023);
    wait_idle("t6");

    // Randomized frames.
    for (int n = 0; n < 25; n++) begin
      f  = 4'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      d  = $urandom_range(1, T + 1);
      busy_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom);
        if (g[7:4] == 4'hA) g[7:4] = 4'h5;
        send_byte(g, 1, 0);
      end
      plan_frame(f, ra, rb, d, 0, 0, 1);
      send_frame(f, ra, rb);
      if (d >= 2 && $urandom_range(0, 2) == 0) send_byte(8'($urandom), 1, 0);
      wait_idle("rnd");
    end
    busy_mode = 0;
    repeat (4) @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer upstream and downstream of the ALU top level. It assembles byte-wide command frames from the receive path into operands A, B and the ALU_FUN field, then fires a single-cycle Enable into the ALU. It captures ALU_OUT on OUT_VALID and streams the 2*WIDTH-bit result back to the transmit path, least-significant byte first. A watchdog converts a missing OUT_VALID into an error byte, so the link never hangs.

## Interface
- WIDTH, 16: ALU operand width; must be a multiple of 8. NB_OP = WIDTH/8 bytes per operand; NB_RES = 2*WIDTH/8 bytes per result.
- TIMEOUT, 15: max cycles to wait for OUT_VALID after Enable; minimum 2.
- ERR_BYTE, 8'hEE: byte sent on timeout.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid this cycle.
- A  out  WIDTH  operand A to ALU.
- B  out  WIDTH  operand B to ALU.
- ALU_FUN  out  4  function code to ALU.
- Enable  out  1  one-cycle ALU start pulse.
- ALU_OUT  in  2*WIDTH  ALU result.
- OUT_VALID  in  1  ALU result valid (sampled only in WAIT).
- TX_P_DATA  out  8  byte to transmitter.
- TX_D_VLD  out  1  TX_P_DATA valid; byte transferred on a cycle with TX_D_VLD=1 and TX_BUSY=0.
- TX_BUSY  in  1  transmitter cannot accept.
- RX_DROP  out  1  one-cycle pulse when an RX byte is discarded.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Frame format: header, then A (NB_OP bytes, LSB first), then B (NB_OP bytes, LSB first).
  - Header upper nibble must be 4'hA; the lower nibble becomes ALU_FUN.
- States: IDLE, GET_A, GET_B, EXEC, WAIT, SEND, ERR.
- IDLE: on RX_D_VLD with header[7:4]==4'hA, latch ALU_FUN and clear the byte counter, then go to GET_A. Any other byte is discarded with RX_DROP=1 and the state stays IDLE.
- GET_A / GET_B: each RX_D_VLD writes RX_P_DATA into byte[cnt] of A/B, then cnt increments.
  - At cnt==NB_OP-1, GET_A goes to GET_B (cnt cleared) and GET_B goes to EXEC.
  - Header values are not checked inside a frame; every byte is payload.
- EXEC: Enable=1 for exactly this one cycle. Watchdog loads 0. Next state is WAIT.
- WAIT: watchdog increments every cycle.
  - OUT_VALID=1: latch ALU_OUT into the result register, set cnt=0, go to SEND.
  - Watchdog reaches TIMEOUT with no OUT_VALID: go to ERR.
  - If OUT_VALID arrives on the same cycle the watchdog reaches TIMEOUT, OUT_VALID wins.
- SEND: TX_P_DATA = result byte[cnt], TX_D_VLD=1.
  - On a transfer (TX_BUSY=0), cnt increments. After byte NB_RES-1 transfers, go to IDLE.
  - While TX_BUSY=1, TX_P_DATA and TX_D_VLD hold their values.
- ERR: TX_P_DATA=ERR_BYTE, TX_D_VLD=1 until transferred, then go to IDLE.
- RX_D_VLD in EXEC, WAIT, SEND or ERR: byte discarded, RX_DROP=1.
- A, B and ALU_FUN are held stable from EXEC until the next frame overwrites them. They are never cleared except by reset.

## Timing
- Reset values: A=0, B=0, ALU_FUN=0, Enable=0, TX_P_DATA=0, TX_D_VLD=0, RX_DROP=0, BUSY=0, state=IDLE, counters=0, result register=0.
- RST high in any state forces these values on the next edge. Any partial frame or pending result is lost.
- All outputs are registered. Enable is high in the cycle after the clock edge that accepts the last B byte.
- WAIT watchdog: OUT_VALID is honoured in cycles 1..TIMEOUT after the Enable cycle. If none arrives, ERR is entered on the next edge.
- SEND: first TX_D_VLD appears the cycle after OUT_VALID is sampled. With TX_BUSY held low, NB_RES bytes go out on consecutive cycles.
- Back-to-back frames: a header is accepted in the first IDLE cycle after the last TX transfer.
- RX_DROP and Enable are never high for more than one consecutive cycle.

## Test plan
- Header 0xA0, then 03 00 04 00. ALU model returns OUT_VALID two cycles after Enable with ALU_OUT=0x00000007. Required: ALU_FUN=0, A=0x0003, B=0x0004, Enable exactly one cycle, TX bytes 07 00 00 00, BUSY low afterwards.
- Bytes 0x55 then 0xA3 12 34 56 78 in IDLE. Required: RX_DROP pulses once for 0x55. A=0x3412, B=0x7856, ALU_FUN=3.
- ALU model never asserts OUT_VALID. Required: TX_P_DATA=0xEE with TX_D_VLD TIMEOUT+1 cycles after Enable, then return to IDLE. A late OUT_VALID arriving after that is ignored.
- Result 0xDEADBEEF with TX_BUSY high for 3 cycles during each byte. Required: each byte is held stable while busy. Order is EF BE AD DE, with no byte skipped or repeated.
- RX byte during WAIT. Required: RX_DROP=1 and A/B unchanged.
- RST asserted mid-GET_B, then a new full frame. Required: all outputs at reset values next cycle, and the new frame executes correctly.
